// File: rtl/conv_chan_sched_if.sv
// Signal bundle between the conv channel scheduler, its requester, the conv engine and the writeback sink.
interface conv_chan_sched_if;
  logic       start;
  logic [3:0] n_chan;
  logic       abort;
  logic       eng_trigger;
  logic [3:0] eng_chan;
  logic       eng_valid;
  logic [3:0] eng_chan_done;
  logic       wb_valid;
  logic [3:0] wb_chan;
  logic       wb_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, n_chan, abort, eng_valid, eng_chan_done, wb_ready,
    output eng_trigger, eng_chan, wb_valid, wb_chan, busy, done, err
  );

  modport slave (
    output start, n_chan, abort, eng_valid, eng_chan_done, wb_ready,
    input  eng_trigger, eng_chan, wb_valid, wb_chan, busy, done, err
  );
endinterface

// File: rtl/conv_chan_sched.sv
// Runs a conv layer channel by channel: trigger the engine, wait for its completion
// with a timeout, hand the result downstream, then advance to the next channel.
//
// state | meaning
// IDLE  | waiting for start
// TRIG  | one-cycle engine trigger for the current channel
// WAIT  | waiting for engine completion, timeout running
// WB    | result offered downstream until accepted
// FIN   | one-cycle done pulse
// ERR   | timeout or wrong channel reported; sets err
module conv_chan_sched #(
  parameter int CHAN    = 10,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  conv_chan_sched_if.master bus
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [3:0]     CHAN_MAX = 4'(CHAN);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, WB, FIN, ERR} state_t;

  state_t        state, state_d;
  logic [3:0]    chan, n_lat, n_clamp;
  logic [TW-1:0] tmr;
  logic          err_q, accept, last_chan;

  assign n_clamp   = (bus.n_chan > CHAN_MAX) ? CHAN_MAX : bus.n_chan;
  assign accept    = (state == IDLE) && bus.start;
  assign last_chan = (chan == n_lat - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start) state_d = (n_clamp == 4'd0) ? FIN : TRIG;
      TRIG: state_d = WAIT;
      WAIT: begin
        if (bus.eng_valid) state_d = (bus.eng_chan_done == chan) ? WB : ERR;
        else if (tmr == '0) state_d = ERR;
      end
      WB:   if (bus.wb_ready) state_d = last_chan ? FIN : TRIG;
      FIN:  state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over every other transition, including into ERR
    if (bus.abort && (state != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan  <= 4'd0;
      n_lat <= 4'd0;
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        n_lat <= n_clamp;
        err_q <= 1'b0;
      end else if (state_d == ERR) begin
        err_q <= 1'b1;
      end

      if (accept || (state_d == IDLE))        chan <= 4'd0;
      else if ((state == WB) && (state_d == TRIG)) chan <= chan + 4'd1;

      // down-counter: TIMEOUT wait cycles elapse before terminal count forces ERR
      if (state == TRIG)                    tmr <= TMR_LOAD;
      else if ((state == WAIT) && (tmr != '0)) tmr <= tmr - 1'b1;
    end
  end

  assign bus.eng_trigger = (state == TRIG);
  assign bus.eng_chan    = chan;
  assign bus.wb_valid    = (state == WB);
  assign bus.wb_chan     = (state == WB) ? chan : 4'd0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FIN);
  assign bus.err         = err_q;

endmodule
